// File: rtl/reg_dump_streamer.sv
// Streams {index, value} beats for every register over valid/ready after a start pulse.
// Optional checksum beat: define REG_DUMP_CKSUM_EN to append the mod-2**DATA_W sum as a final beat.
module reg_dump_streamer #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_index,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    output logic              dump_is_cksum,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_SEND  = 3'd2,
        S_DONE  = 3'd3
`ifdef REG_DUMP_CKSUM_EN
        ,
        S_CKSUM = 3'd4
`endif
    } state_t;

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] idx_r, idx_s;
    logic              valid_r, valid_s;
    logic [ADDR_W-1:0] index_r, index_s;
    logic [DATA_W-1:0] data_r, data_s;
    logic              last_r, last_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
`ifdef REG_DUMP_CKSUM_EN
    logic [DATA_W-1:0] sum_r, sum_s;
    logic              cks_r, cks_s;

    function automatic logic [DATA_W-1:0] cksum_add(input logic [DATA_W-1:0] acc,
                                                    input logic [DATA_W-1:0] val);
        return acc + val;
    endfunction
`endif

    // Next-state and next-output decode; abort outranks every other transition.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        valid_s = valid_r;
        index_s = index_r;
        data_s  = data_r;
        last_s  = last_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
`ifdef REG_DUMP_CKSUM_EN
        sum_s   = sum_r;
        cks_s   = cks_r;
`endif
        if (abort && (state_r != S_IDLE)) begin
            state_s = S_IDLE;
            valid_s = 1'b0;
            last_s  = 1'b0;
            busy_s  = 1'b0;
`ifdef REG_DUMP_CKSUM_EN
            cks_s   = 1'b0;
`endif
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        state_s = S_READ;
                        idx_s   = '0;
                        busy_s  = 1'b1;
`ifdef REG_DUMP_CKSUM_EN
                        sum_s   = '0;
`endif
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_READ: begin
                    state_s = S_SEND;
                    valid_s = 1'b1;
                    index_s = idx_r;
                    data_s  = rf_rdata;
`ifdef REG_DUMP_CKSUM_EN
                    last_s  = 1'b0;
                    sum_s   = cksum_add(sum_r, rf_rdata);
`else
                    last_s  = (idx_r == LAST_IDX);
`endif
                end
                S_SEND: begin
                    if (dump_ready) begin
                        valid_s = 1'b0;
                        last_s  = 1'b0;
                        if (idx_r == LAST_IDX) begin
`ifdef REG_DUMP_CKSUM_EN
                            state_s = S_CKSUM;
                            valid_s = 1'b1;
                            index_s = '0;
                            data_s  = sum_r;
                            last_s  = 1'b1;
                            cks_s   = 1'b1;
`else
                            state_s = S_DONE;
                            done_s  = 1'b1;
`endif
                        end else begin
                            idx_s   = idx_r + ADDR_W'(1);
                            state_s = S_READ;
                        end
                    end else begin
                        state_s = S_SEND;
                    end
                end
`ifdef REG_DUMP_CKSUM_EN
                S_CKSUM: begin
                    if (dump_ready) begin
                        state_s = S_DONE;
                        done_s  = 1'b1;
                        valid_s = 1'b0;
                        last_s  = 1'b0;
                        cks_s   = 1'b0;
                    end else begin
                        state_s = S_CKSUM;
                    end
                end
`endif
                S_DONE: begin
                    state_s = S_IDLE;
                    busy_s  = 1'b0;
                end
                default: begin
                    state_s = S_IDLE;
                    valid_s = 1'b0;
                    last_s  = 1'b0;
                    busy_s  = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs; reset drops any dump in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
            idx_r   <= '0;
            valid_r <= 1'b0;
            index_r <= '0;
            data_r  <= '0;
            last_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef REG_DUMP_CKSUM_EN
            sum_r   <= '0;
            cks_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            valid_r <= valid_s;
            index_r <= index_s;
            data_r  <= data_s;
            last_r  <= last_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
`ifdef REG_DUMP_CKSUM_EN
            sum_r   <= sum_s;
            cks_r   <= cks_s;
`endif
        end
    end

    // The read address is the walk index itself, so it freezes while a beat is stalled.
    assign rf_raddr   = idx_r;
    assign dump_valid = valid_r;
    assign dump_index = index_r;
    assign dump_data  = data_r;
    assign dump_last  = last_r;
    assign busy       = busy_r;
    assign done       = done_r;
`ifdef REG_DUMP_CKSUM_EN
    assign dump_is_cksum = cks_r;
`else
    assign dump_is_cksum = 1'b0;
`endif

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Self-checking bench for reg_dump_streamer: scenario table, beat scoreboard, abort and reset sequences.
module tb_reg_dump_streamer;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
`ifdef REG_DUMP_CKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    localparam int NBEATS = NUM_REGS + CK;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              dump_ready = 1'b0;
    logic [ADDR_W-1:0] rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic              dump_valid;
    logic [ADDR_W-1:0] dump_index;
    logic [DATA_W-1:0] dump_data;
    logic              dump_last;
    logic              dump_is_cksum;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] rf   [NUM_REGS];
    logic [DATA_W-1:0] snap [NUM_REGS];
    assign rf_rdata = rf[rf_raddr];

    reg_dump_streamer #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_index(dump_index), .dump_data(dump_data),
        .dump_last(dump_last), .dump_is_cksum(dump_is_cksum),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] data;
        logic              last;
        logic              cksum;
    } beat_t;

    typedef struct {
        int data_mode;    // 0: 0x1000_0000+i, 1: random
        int ready_mode;   // 0: always 1, 1: toggle, 2: random
        int stall_idx;    // -1: none
        int stall_len;
        int extra_start;  // beat count at which a stray start is pulsed, -1: none
        bit timing;
        int exp_beats;
        int exp_done;
    } vec_t;

    beat_t exp_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int beats_seen = 0;
    int done_count = 0;
    int cyc = 0;
    int start_cyc = 0;
    int last_reg_cyc = 0;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Scoreboard: checks each accepted beat, hold-while-stalled, and the done pulse position.
    initial begin : monitor
        bit                prev_pending;
        logic [38:0]       prev_beat;
        bit                exp_done;
        bit                next_done;
        beat_t             b;
        prev_pending = 1'b0;
        prev_beat    = '0;
        exp_done     = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_pending = 1'b0;
                exp_done     = 1'b0;
            end else begin
                if (prev_pending)
                    check_eq("hold_beat", {dump_valid, dump_index, dump_data, dump_last}, prev_beat);
                check_eq("done_pulse", done, exp_done);
                next_done = 1'b0;
                if (dump_valid && dump_ready && !abort) begin
                    beats_seen++;
                    check_eq("beat_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        b = exp_q.pop_front();
                        check_eq("beat_index", dump_index, b.idx);
                        check_eq("beat_data", dump_data, b.data);
                        check_eq("beat_last", dump_last, b.last);
                        check_eq("beat_cksum", dump_is_cksum, b.cksum);
                        next_done = b.last;
                        if (!b.cksum && b.idx == ADDR_W'(NUM_REGS - 1))
                            last_reg_cyc = cyc;
                    end
                end
                if (done)
                    done_count++;
                exp_done     = next_done;
                prev_pending = dump_valid && !dump_ready && !abort;
                prev_beat    = {dump_valid, dump_index, dump_data, dump_last};
            end
        end
    end

    task automatic fill_rf(input int mode);
        for (int i = 0; i < NUM_REGS; i++)
            rf[i] = (mode == 0) ? (32'h1000_0000 + DATA_W'(i)) : DATA_W'($urandom);
    endtask

    // Reference stream: every register in order, then the checksum beat when enabled.
    task automatic build_model();
        beat_t b;
        logic [DATA_W-1:0] sum;
        exp_q.delete();
        sum = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            snap[i] = rf[i];
            sum     = sum + rf[i];
            b.idx   = ADDR_W'(i);
            b.data  = rf[i];
            b.last  = (CK == 0) && (i == NUM_REGS - 1);
            b.cksum = 1'b0;
            exp_q.push_back(b);
        end
`ifdef REG_DUMP_CKSUM_EN
        b.idx   = '0;
        b.data  = sum;
        b.last  = 1'b1;
        b.cksum = 1'b1;
        exp_q.push_back(b);
`endif
    endtask

    task automatic do_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        start_cyc = cyc;
        check_eq("busy_after_start", busy, 1);
    endtask

    task automatic run_dump(input vec_t v);
        int  n;
        int  stall_left;
        bit  stalled;
        bit  extra_done;
        bit  tog;
        fill_rf(v.data_mode);
        build_model();
        beats_seen = 0;
        done_count = 0;
        dump_ready = 1'b1;
        do_start();
        n = 0; stall_left = 0; stalled = 1'b0; extra_done = 1'b0; tog = 1'b0;
        while (done_count == 0 && n < 4000) begin
            @(posedge clk);
            #1;
            n++;
            start = 1'b0;
            if (v.extra_start >= 0 && !extra_done && beats_seen == v.extra_start) begin
                start      = 1'b1;
                extra_done = 1'b1;
            end
            if (v.stall_idx >= 0 && !stalled && dump_valid && dump_index == ADDR_W'(v.stall_idx)) begin
                stalled    = 1'b1;
                stall_left = v.stall_len;
                rf[v.stall_idx] = ~rf[v.stall_idx];
            end
            if (stall_left > 0) begin
                dump_ready = 1'b0;
                stall_left--;
                check_eq("stall_valid", dump_valid, 1);
                check_eq("stall_data", dump_data, snap[v.stall_idx]);
            end else begin
                case (v.ready_mode)
                    0: dump_ready = 1'b1;
                    1: begin tog = !tog; dump_ready = tog; end
                    default: dump_ready = 1'($urandom_range(0, 1));
                endcase
            end
        end
        start = 1'b0;
        check_eq("dump_timeout", done_count, v.exp_done);
        check_eq("busy_after_done", busy, 0);
        check_eq("valid_after_done", dump_valid, 0);
        check_eq("beat_count", beats_seen, v.exp_beats);
        check_eq("beats_left", exp_q.size(), 0);
        if (v.timing)
            check_eq("first_read_to_last_hs", last_reg_cyc - start_cyc, 2 * NUM_REGS - 1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("idle_valid", dump_valid, 0);
        check_eq("idle_busy", busy, 0);
        check_eq("done_once", done_count, 1);
    endtask

    task automatic wait_index(input int idx, input string name);
        int n;
        n = 0;
        while (!(dump_valid && dump_index == ADDR_W'(idx)) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq(name, dump_valid && dump_index == ADDR_W'(idx), 1);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{0, 0, -1, 0, -1, 1'b1, NBEATS, 1};
        vecs[1] = '{0, 1, 5, 10, -1, 1'b0, NBEATS, 1};
        vecs[2] = '{0, 0, -1, 0, 3, 1'b1, NBEATS, 1};
        vecs[3] = '{1, 2, -1, 0, -1, 1'b0, NBEATS, 1};
        vecs[4] = '{1, 0, -1, 0, NBEATS, 1'b1, NBEATS, 1};
        vecs[5] = '{1, 1, NUM_REGS - 1, 4, 17, 1'b0, NBEATS, 1};

        fill_rf(0);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_outputs",
                 {rf_raddr, dump_valid, dump_index, dump_data, dump_last, dump_is_cksum, busy, done}, 0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("idle_no_start", {dump_valid, busy, done}, 0);

        for (int k = 0; k < 6; k++)
            run_dump(vecs[k]);

        // Abort while index 12 is presented with ready high: that beat must not complete.
        fill_rf(0);
        build_model();
        beats_seen = 0;
        done_count = 0;
        dump_ready = 1'b1;
        do_start();
        wait_index(12, "abort_reach_12");
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check_eq("abort_valid", dump_valid, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_beats", beats_seen, 12);
        repeat (5) @(posedge clk);
        #1;
        check_eq("abort_no_done", done_count, 0);
        check_eq("abort_still_idle", {dump_valid, busy}, 0);
        check_eq("abort_left", exp_q.size(), NBEATS - 12);
        exp_q.delete();
        run_dump(vecs[0]);

        // Asynchronous reset in the middle of a cycle during index 20.
        fill_rf(0);
        build_model();
        beats_seen = 0;
        done_count = 0;
        dump_ready = 1'b1;
        do_start();
        wait_index(20, "reset_reach_20");
        #2 reset = 1'b0;
        #1;
        check_eq("async_reset_outputs",
                 {rf_raddr, dump_valid, dump_index, dump_data, dump_last, dump_is_cksum, busy, done}, 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check_eq("post_reset_idle", {dump_valid, busy, done}, 0);
        check_eq("post_reset_no_done", done_count, 0);
        run_dump(vecs[3]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_dump_streamer.md
Name: reg_dump_streamer

Overview:
- Hardware-side producer of an end-of-run register dump for the pipelined MIPS machine.
- On a start pulse, walks the register file through a dedicated read port and streams one {index, value} beat per register over a valid/ready interface.
- A host-side bench or debug link consumes the beats, replacing hierarchical peeks into the register file.
- Sits beside the register file as a second read port; never writes architectural state.

Parameters:
- NUM_REGS, 32, number of registers streamed, indices 0..NUM_REGS-1
- ADDR_W, 5, register index width; NUM_REGS <= 2**ADDR_W
- DATA_W, 32, register data width

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low; 0 = reset asserted
- start  input  1  one-cycle request to begin a dump; honoured only in IDLE
- abort  input  1  synchronous cancel; returns to IDLE next edge
- rf_raddr  output  ADDR_W  register file read address
- rf_rdata  input  DATA_W  combinational read data for rf_raddr
- dump_valid  output  1  beat available
- dump_ready  input  1  consumer accepts beat when valid & ready at rising edge
- dump_index  output  ADDR_W  register index of current beat
- dump_data  output  DATA_W  register value of current beat
- dump_last  output  1  current beat is the final beat
- dump_is_cksum  output  1  current beat is the checksum beat; tied 0 without feature
- busy  output  1  high from the cycle after start accept until DONE exit
- done  output  1  one-cycle pulse after final beat handshake

Behaviour:
- Reset (reset=0, async): state IDLE, idx=0. All outputs 0: rf_raddr=0, dump_valid=0, dump_index=0, dump_data=0, dump_last=0, dump_is_cksum=0, busy=0, done=0. Reset mid-dump discards the dump; no further beats.
- States: IDLE, READ, SEND, DONE (plus CKSUM with feature).
- IDLE: start=1 -> READ, idx=0, busy=1 from next cycle. start while busy is ignored.
- READ (1 cycle): rf_raddr=idx. At edge, capture rf_rdata into dump_data and idx into dump_index, then go to SEND.
- SEND: dump_valid=1. dump_index, dump_data and dump_last are held stable until handshake; valid never drops without a handshake (abort/reset excepted).
  - Handshake with idx<NUM_REGS-1: idx+1 -> READ.
  - Handshake with idx=NUM_REGS-1: -> DONE, or CKSUM with feature.
  - dump_last=1 only on the final beat.
- DONE (1 cycle): done=1, busy=0 next cycle, -> IDLE. A start in the DONE cycle is ignored.
- Throughput: 2 cycles per beat minimum (READ+SEND with ready=1). Full dump of 32 registers = 64 cycles from first READ to last handshake; done asserts the following cycle.
- Backpressure: ready=0 stalls in SEND indefinitely; rf_raddr is not updated.
- abort=1 in any non-IDLE state: -> IDLE at next edge; dump_valid=0, busy=0, no done pulse. abort in IDLE has no effect. abort overrides a simultaneous handshake.
- Register 0 is streamed like any other (value as read, normally 0).
- rf_rdata is sampled only in READ; changes during SEND do not affect the held beat.

Optional Feature:
- Macro REG_DUMP_CKSUM_EN.
- Defined:
  - An accumulator sums every captured value mod 2**DATA_W; it is cleared on start accept.
  - After the register NUM_REGS-1 handshake, state CKSUM presents one extra beat: dump_data=sum, dump_index=0, dump_is_cksum=1, dump_last=1.
  - Register NUM_REGS-1's beat has dump_last=0.
  - CKSUM handshake -> DONE.
- Undefined: no accumulator, no CKSUM state; dump_is_cksum is constant 0; dump_last is set on register NUM_REGS-1.

Test Plan:
- Basic dump: r[i]=32'h1000_0000+i, ready=1, pulse start -> 32 beats, indices 0..31, data 0x10000000..0x1000001F. dump_last only on index 31. done pulse exactly 1 cycle after last handshake; 64 cycles from first READ to last handshake.
- Backpressure: ready toggles 1/0 every cycle, with ready held 0 for 10 cycles at index 5 -> beat 5 stays valid, data 0x10000005 stable throughout. No skipped or duplicated indices.
- Start while busy: second start pulse at beat 3 -> ignored; exactly 32 beats, one done pulse.
- Abort: assert abort in SEND of index 12 with ready=1 -> no handshake for index 12; valid=0 and busy=0 next cycle, no done pulse. A new start then restarts at index 0.
- Async reset: drive reset=0 mid-cycle during index 20 -> all outputs 0 immediately without a clock edge. After release, idle until start.
- Checksum (REG_DUMP_CKSUM_EN, same r[i]) -> 33 beats; final beat dump_is_cksum=1, dump_last=1, data 32'h0000_01F0. Index 31 beat has dump_last=0.
